hwpe_stream_copy_checker: RTL and testbench

Terminal stage of the HWPE stream copy network: sits downstream of the copy path and sits beside the original stream at a sink point. It drives the copy stream's ready from the original stream's ready, recomputes the reduced copy from the original beat, and compares it against the received copy. Mismatches are pipelined into a per-cycle fault pulse, a sticky fault state, a saturating fault counter and a first-fault capture for software/safety-island readout.

---
 rtl/hwpe_stream_copy_checker.sv | 156 +++++++++++++++
 tb/tb_hwpe_stream_copy_checker.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_copy_checker.sv
// Terminal checker of the HWPE stream copy network. Sits beside the original
// stream at a sink point, forwards its ready to the copy stream, recomputes the
// reduced copy from each original beat and compares it against the received copy.
// Mismatches become a one-cycle fault pulse, a sticky state, a saturating
// counter and a first-fault capture.
//
// COPY_TYPE encoding: 0 = COPY, 1 = PARITY, 2 = STRB_ONLY, 3 = ZERO.
// Copy stream widths follow the copy type:
//   COPY      data DATA_WIDTH, strb STRB_WIDTH
//   PARITY    data STRB_WIDTH (one parity bit per lane), strb STRB_WIDTH
//   STRB_ONLY data 1 (ignored), strb STRB_WIDTH
//   ZERO      data 1 (ignored), strb 1 (ignored)
module hwpe_stream_copy_checker #(
  parameter int unsigned COPY_TYPE  = 0,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned BEAT_WIDTH = 16,
  localparam int unsigned TypeCopy     = 0,
  localparam int unsigned TypeParity   = 1,
  localparam int unsigned TypeStrbOnly = 2,
  localparam int unsigned TypeZero     = 3,
  localparam int unsigned CopyDataWidth =
      (COPY_TYPE == TypeCopy) ? DATA_WIDTH : (COPY_TYPE == TypeParity) ? STRB_WIDTH : 1,
  localparam int unsigned CopyStrbWidth = (COPY_TYPE == TypeZero) ? 1 : STRB_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // original stream, monitored only
  input  logic                     original_valid_i,
  input  logic                     original_ready_i,
  input  logic [DATA_WIDTH-1:0]    original_data_i,
  input  logic [STRB_WIDTH-1:0]    original_strb_i,
  // copy stream, terminated here
  input  logic                     copy_valid_i,
  output logic                     copy_ready_o,
  input  logic [CopyDataWidth-1:0] copy_data_i,
  input  logic [CopyStrbWidth-1:0] copy_strb_i,
  input  logic                     clear_fault_i,
  output logic                     fault_o,
  output logic                     fault_sticky_o,
  output logic [CNT_WIDTH-1:0]     fault_cnt_o,
  output logic [2:0]               first_fault_type_o,
  output logic [BEAT_WIDTH-1:0]    first_fault_beat_o
);

  localparam int unsigned LaneWidth = DATA_WIDTH / STRB_WIDTH;

  typedef enum logic [0:0] {StOk, StFaulted} state_e;

  logic                  hs;
  logic                  valid_mm, data_mm, strb_mm;
  logic [2:0]            flags_q;
  logic [BEAT_WIDTH-1:0] beat_cnt_q, beat_q;
  state_e                state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [2:0]            type_q;
  logic [BEAT_WIDTH-1:0] fbeat_q;
  logic                  unused_inputs;

  if (DATA_WIDTH % STRB_WIDTH != 0) begin : gen_bad_width
    $fatal(1, "DATA_WIDTH must be a multiple of STRB_WIDTH");
  end

  // The copy path never back-pressures on its own: it follows the original sink.
  assign copy_ready_o = original_ready_i;
  assign hs           = original_valid_i & original_ready_i;
  assign valid_mm     = original_valid_i != copy_valid_i;

  // Some copy types ignore part of the inputs; fold them here so nothing dangles.
  assign unused_inputs = ^{copy_data_i, copy_strb_i, original_data_i, original_strb_i};

  if (COPY_TYPE == TypeCopy) begin : gen_copy
    assign data_mm = hs & (copy_data_i != original_data_i);
    assign strb_mm = hs & (copy_strb_i != original_strb_i);
  end else if (COPY_TYPE == TypeParity) begin : gen_parity
    logic [STRB_WIDTH-1:0] lane_parity;
    // Per-lane XOR of the original data; strobes do not mask lanes.
    always_comb begin
      lane_parity = '0;
      for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
        lane_parity[i] = ^original_data_i[i*LaneWidth +: LaneWidth];
      end
    end
    assign data_mm = hs & (copy_data_i != lane_parity);
    assign strb_mm = hs & (copy_strb_i != original_strb_i);
  end else if (COPY_TYPE == TypeStrbOnly) begin : gen_strb_only
    assign data_mm = 1'b0;
    assign strb_mm = hs & (copy_strb_i != original_strb_i);
  end else if (COPY_TYPE == TypeZero) begin : gen_zero
    assign data_mm = 1'b0;
    assign strb_mm = 1'b0;
  end else begin : gen_bad_type
    $fatal(1, "unsupported COPY_TYPE");
  end

  // Stage 1: register mismatch flags with the beat index they belong to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_q    <= '0;
      beat_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      flags_q <= {strb_mm, data_mm, valid_mm};
      beat_q  <= beat_cnt_q;
      if (hs) beat_cnt_q <= beat_cnt_q + BEAT_WIDTH'(1);
    end
  end

  assign fault_o = |flags_q;

  // Stage 2: sticky fault state, saturating counter and first-fault capture.
  // A new fault in the same cycle as a clear wins and restarts the capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StOk;
      cnt_q   <= '0;
      type_q  <= '0;
      fbeat_q <= '0;
    end else begin
      unique case (state_q)
        StOk: begin
          if (|flags_q) begin
            state_q <= StFaulted;
            type_q  <= flags_q;
            fbeat_q <= beat_q;
            cnt_q   <= CNT_WIDTH'(1);
          end
        end
        StFaulted: begin
          if (|flags_q) begin
            if (clear_fault_i) begin
              type_q  <= flags_q;
              fbeat_q <= beat_q;
              cnt_q   <= CNT_WIDTH'(1);
            end else if (cnt_q != '1) begin
              cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
          end else if (clear_fault_i) begin
            state_q <= StOk;
            type_q  <= '0;
            fbeat_q <= '0;
            cnt_q   <= '0;
          end
        end
        default: state_q <= StOk;
      endcase
    end
  end

  assign fault_sticky_o     = (state_q == StFaulted);
  assign fault_cnt_o        = cnt_q;
  assign first_fault_type_o = type_q;
  assign first_fault_beat_o = fbeat_q;

endmodule

// File: tb/tb_hwpe_stream_copy_checker.sv
// Bench for hwpe_stream_copy_checker: a COPY and a PARITY instance watch the same
// original stream, each with its own copy stream, against a cycle-level model.
module tb_hwpe_stream_copy_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rst, clear;
  logic        o_valid, o_ready;
  logic [31:0] o_data;
  logic [3:0]  o_strb;
  // COPY instance copy stream and outputs
  logic        c_valid, c_ready;
  logic [31:0] c_data;
  logic [3:0]  c_strb;
  logic        c_fault, c_sticky;
  logic [7:0]  c_cnt;
  logic [2:0]  c_type;
  logic [15:0] c_beat;
  // PARITY instance copy stream and outputs
  logic        p_valid, p_ready;
  logic [3:0]  p_data;
  logic [3:0]  p_strb;
  logic        p_fault, p_sticky;
  logic [7:0]  p_cnt;
  logic [2:0]  p_type;
  logic [15:0] p_beat;

  hwpe_stream_copy_checker #(
    .COPY_TYPE (0),
    .DATA_WIDTH(32),
    .STRB_WIDTH(4),
    .CNT_WIDTH (8),
    .BEAT_WIDTH(16)
  ) u_dut_copy (
    .clk_i             (clk),
    .rst_i             (rst),
    .original_valid_i  (o_valid),
    .original_ready_i  (o_ready),
    .original_data_i   (o_data),
    .original_strb_i   (o_strb),
    .copy_valid_i      (c_valid),
    .copy_ready_o      (c_ready),
    .copy_data_i       (c_data),
    .copy_strb_i       (c_strb),
    .clear_fault_i     (clear),
    .fault_o           (c_fault),
    .fault_sticky_o    (c_sticky),
    .fault_cnt_o       (c_cnt),
    .first_fault_type_o(c_type),
    .first_fault_beat_o(c_beat)
  );

  hwpe_stream_copy_checker #(
    .COPY_TYPE (1),
    .DATA_WIDTH(32),
    .STRB_WIDTH(4),
    .CNT_WIDTH (8),
    .BEAT_WIDTH(16)
  ) u_dut_par (
    .clk_i             (clk),
    .rst_i             (rst),
    .original_valid_i  (o_valid),
    .original_ready_i  (o_ready),
    .original_data_i   (o_data),
    .original_strb_i   (o_strb),
    .copy_valid_i      (p_valid),
    .copy_ready_o      (p_ready),
    .copy_data_i       (p_data),
    .copy_strb_i       (p_strb),
    .clear_fault_i     (clear),
    .fault_o           (p_fault),
    .fault_sticky_o    (p_sticky),
    .fault_cnt_o       (p_cnt),
    .first_fault_type_o(p_type),
    .first_fault_beat_o(p_beat)
  );

  // Model state, index 0 = COPY instance, 1 = PARITY instance.
  int m_flags[2];   // mismatch seen in the previous cycle (bit2 strb, bit1 data, bit0 valid)
  int m_pbeat[2];   // beat index of that previous cycle
  int m_beats[2];   // handshakes so far, modulo 2^16
  bit m_sticky[2];
  int m_cnt[2];
  int m_type[2];
  int m_fbeat[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lane parity from population counts of each byte.
  function automatic logic [3:0] ref_parity(input logic [31:0] d);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (($countones(d[8*i +: 8]) % 2) == 1);
    return r;
  endfunction

  function automatic int calc_flags(input int k);
    bit hs, vmm, dmm, smm;
    hs = o_valid && o_ready;
    if (k == 0) begin
      vmm = (o_valid != c_valid);
      dmm = hs && (o_data != c_data);
      smm = hs && (o_strb != c_strb);
    end else begin
      vmm = (o_valid != p_valid);
      dmm = hs && (ref_parity(o_data) != p_data);
      smm = hs && (o_strb != p_strb);
    end
    return (smm ? 4 : 0) + (dmm ? 2 : 0) + (vmm ? 1 : 0);
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_flags[k] = 0; m_pbeat[k] = 0; m_beats[k] = 0;
        m_sticky[k] = 1'b0; m_cnt[k] = 0; m_type[k] = 0; m_fbeat[k] = 0;
      end else begin
        if (m_flags[k] != 0) begin
          if (!m_sticky[k] || clear) begin
            m_cnt[k] = 1; m_type[k] = m_flags[k]; m_fbeat[k] = m_pbeat[k];
          end else if (m_cnt[k] < 255) begin
            m_cnt[k]++;
          end
          m_sticky[k] = 1'b1;
        end else if (clear && m_sticky[k]) begin
          m_sticky[k] = 1'b0; m_cnt[k] = 0; m_type[k] = 0; m_fbeat[k] = 0;
        end
        m_flags[k] = calc_flags(k);
        m_pbeat[k] = m_beats[k];
        if (o_valid && o_ready) m_beats[k] = (m_beats[k] + 1) % 65536;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("c_fault", c_fault, m_flags[0] != 0);
    check_eq("c_sticky", c_sticky, m_sticky[0]);
    check_eq("c_cnt", c_cnt, m_cnt[0]);
    check_eq("c_type", c_type, m_type[0]);
    check_eq("c_beat", c_beat, m_fbeat[0]);
    check_eq("p_fault", p_fault, m_flags[1] != 0);
    check_eq("p_sticky", p_sticky, m_sticky[1]);
    check_eq("p_cnt", p_cnt, m_cnt[1]);
    check_eq("p_type", p_type, m_type[1]);
    check_eq("p_beat", p_beat, m_fbeat[1]);
  endtask

  // Inputs are set just after an edge; this checks ready, clocks once and compares.
  task automatic step();
    #1;
    check_eq("c_ready", c_ready, o_ready);
    check_eq("p_ready", p_ready, o_ready);
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive_match();
    c_valid = o_valid; c_data = o_data; c_strb = o_strb;
    p_valid = o_valid; p_data = ref_parity(o_data); p_strb = o_strb;
  endtask

  task automatic set_quiet();
    o_valid = 1'b0; o_ready = 1'b0; o_data = '0; o_strb = '0;
    drive_match();
  endtask

  task automatic rand_orig();
    o_valid = ($urandom_range(0, 3) != 0);
    o_ready = ($urandom_range(0, 3) != 0);
    o_data  = $urandom;
    o_strb  = 4'($urandom);
  endtask

  initial begin
    int hs_count;
    int pulses;
    bit any_fault;
    int sel;

    rst = 1'b1; clear = 1'b0;
    set_quiet();
    step();
    step();
    rst = 1'b0;

    // 100 matching beats with random stalls
    hs_count = 0; any_fault = 1'b0;
    while (hs_count < 100) begin
      rand_orig();
      drive_match();
      if (o_valid && o_ready) hs_count++;
      step();
      any_fault |= c_fault | p_fault;
    end
    set_quiet();
    step();
    any_fault |= c_fault | p_fault;
    check_eq("match_no_fault", any_fault, 1'b0);
    check_eq("match_c_cnt", c_cnt, 8'd0);

    // copy valid stuck low for 3 cycles while original waits
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        o_valid = 1'b1; o_ready = 1'b0; drive_match();
        c_valid = 1'b0; p_valid = 1'b0;
      end else begin
        set_quiet();
      end
      step();
      pulses += int'(c_fault);
    end
    check_eq("stuck_pulses", pulses, 3);
    check_eq("stuck_c_cnt", c_cnt, 8'd3);
    check_eq("stuck_c_type", c_type, 3'b001);
    check_eq("stuck_c_beat", c_beat, 16'd100);
    check_eq("stuck_p_cnt", p_cnt, 8'd3);
    check_eq("stuck_p_beat", p_beat, 16'd100);

    // clear on a quiet cycle
    clear = 1'b1; step(); clear = 1'b0;
    check_eq("clr_c_sticky", c_sticky, 1'b0);
    check_eq("clr_c_cnt", c_cnt, 8'd0);
    check_eq("clr_c_type", c_type, 3'b000);

    // parity fault on beat 5
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      o_valid = 1'b1; o_ready = 1'b1; o_data = $urandom; o_strb = 4'hf;
      drive_match();
      step();
    end
    o_data = 32'h0000_0100; drive_match(); p_data = 4'b0000;
    step();
    check_eq("par_fault_pulse", p_fault, 1'b1);
    check_eq("par_not_sticky_yet", p_sticky, 1'b0);
    check_eq("par_copy_quiet", c_fault, 1'b0);
    set_quiet();
    step();
    check_eq("par_fault_end", p_fault, 1'b0);
    check_eq("par_sticky", p_sticky, 1'b1);
    check_eq("par_type", p_type, 3'b010);
    check_eq("par_beat", p_beat, 16'd5);

    // clear coinciding with a fresh fault: fault wins
    o_valid = 1'b1; o_ready = 1'b0; drive_match(); p_valid = 1'b0;
    step();
    set_quiet(); clear = 1'b1; step(); clear = 1'b0;
    check_eq("clrhit_sticky", p_sticky, 1'b1);
    check_eq("clrhit_cnt", p_cnt, 8'd1);
    check_eq("clrhit_type", p_type, 3'b001);
    check_eq("clrhit_beat", p_beat, 16'd6);
    clear = 1'b1; step(); clear = 1'b0;
    check_eq("clrq_sticky", p_sticky, 1'b0);
    check_eq("clrq_cnt", p_cnt, 8'd0);
    check_eq("clrq_beat", p_beat, 16'd0);

    // counter saturation
    for (int i = 0; i < 300; i++) begin
      o_valid = 1'b1; o_ready = 1'b0; drive_match();
      c_valid = 1'b0; p_valid = 1'b0;
      step();
    end
    set_quiet();
    step();
    step();
    check_eq("sat_c_cnt", c_cnt, 8'd255);
    check_eq("sat_p_cnt", p_cnt, 8'd255);

    // reset one cycle after a mismatch
    clear = 1'b1; step(); clear = 1'b0;
    o_valid = 1'b1; o_ready = 1'b0; drive_match(); c_valid = 1'b0;
    step();
    set_quiet(); rst = 1'b1; step(); rst = 1'b0;
    step();
    check_eq("rst_fault", c_fault, 1'b0);
    check_eq("rst_sticky", c_sticky, 1'b0);
    check_eq("rst_cnt", c_cnt, 8'd0);
    step();
    check_eq("rst_no_late", c_fault, 1'b0);

    // random traffic with injected corruption, clears and resets
    for (int i = 0; i < 3000; i++) begin
      rand_orig();
      drive_match();
      if ($urandom_range(0, 7) == 0) begin
        sel = int'($urandom_range(0, 5));
        case (sel)
          0: c_valid = ~c_valid;
          1: c_data  = c_data ^ (32'd1 << $urandom_range(0, 31));
          2: c_strb  = c_strb ^ (4'd1 << $urandom_range(0, 3));
          3: p_data  = p_data ^ (4'd1 << $urandom_range(0, 3));
          4: p_strb  = p_strb ^ (4'd1 << $urandom_range(0, 3));
          default: p_valid = ~p_valid;
        endcase
      end
      clear = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      step();
    end
    clear = 1'b0; rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
